// File: rtl/snd_volramp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// snd_volramp : stereo gain stage with linear volume ramp, mute, rounding and
//               16-bit saturation. One multiplier is shared between L and R.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module snd_volramp #(
  parameter int RAMP_STEP = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VLD,
  input  logic [15:0] IN_L,
  input  logic [15:0] IN_R,
  input  logic [7:0]  REG_VOLUME,
  input  logic        REG_MUTE,
  output logic        OUT_VLD,
  output logic [15:0] OUT_L,
  output logic [15:0] OUT_R,
  output logic [7:0]  CUR_GAIN,
  output logic        RAMP_BUSY,
  output logic [7:0]  DROP_CNT
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_MUL_L = 2'd1;
  localparam logic [1:0] c_ST_MUL_R = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;
  localparam logic [8:0] c_STEP     = 9'(RAMP_STEP);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [15:0]        r_in_l;
  logic [15:0]        r_in_r;
  logic [15:0]        r_hold_l;
  logic [15:0]        r_out_l;
  logic [15:0]        r_out_r;
  logic [7:0]         r_gain;
  logic [7:0]         r_gain_used;
  logic [7:0]         r_drop;
  logic [7:0]         w_target;
  logic [7:0]         w_gain_nxt;
  logic [8:0]         w_diff;
  logic               w_accept;
  logic               w_drop;
  logic               w_out_vld;
  logic [15:0]        w_mul_a;
  logic signed [24:0] w_a_ext;
  logic signed [24:0] w_g_ext;
  logic signed [24:0] w_prod;
  logic signed [24:0] w_rnd;
  logic signed [24:0] w_shr;
  logic [15:0]        w_sat;

  assign w_target = REG_MUTE ? 8'd0 : REG_VOLUME;
  assign w_accept = IN_VLD && (r_state == c_ST_IDLE);
  assign w_drop   = IN_VLD && (r_state != c_ST_IDLE);

  // Ramp one step toward target, snapping when within one step (no overshoot/wrap).
  always_comb begin
    w_gain_nxt = r_gain;
    w_diff     = 9'd0;
    if (w_target >= r_gain) begin
      w_diff = {1'b0, w_target} - {1'b0, r_gain};
      if (w_diff <= c_STEP) w_gain_nxt = w_target;
      else                  w_gain_nxt = r_gain + c_STEP[7:0];
    end else begin
      w_diff = {1'b0, r_gain} - {1'b0, w_target};
      if (w_diff <= c_STEP) w_gain_nxt = w_target;
      else                  w_gain_nxt = r_gain - c_STEP[7:0];
    end
  end

  assign w_mul_a = (r_state == c_ST_MUL_L) ? r_in_l : r_in_r;
  assign w_a_ext = {{9{w_mul_a[15]}}, w_mul_a};
  assign w_g_ext = {17'd0, r_gain_used};
  assign w_prod  = w_a_ext * w_g_ext;
  assign w_rnd   = w_prod + 25'sd64;
  assign w_shr   = w_rnd >>> 7;

  always_comb begin
    w_sat = w_shr[15:0];
    if (w_shr[24:15] != {10{w_shr[24]}}) w_sat = w_shr[24] ? 16'h8000 : 16'h7FFF;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= c_ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (IN_VLD) w_state_nxt = c_ST_MUL_L;
      c_ST_MUL_L: w_state_nxt = c_ST_MUL_R;
      c_ST_MUL_R: w_state_nxt = c_ST_DONE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_out_vld = (r_state == c_ST_DONE);
  end

  // Both outputs are written on the edge entering DONE so they are valid with OUT_VLD.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_in_l      <= 16'd0;
      r_in_r      <= 16'd0;
      r_hold_l    <= 16'd0;
      r_out_l     <= 16'd0;
      r_out_r     <= 16'd0;
      r_gain      <= 8'd0;
      r_gain_used <= 8'd0;
      r_drop      <= 8'd0;
    end else begin
      if (w_accept) begin
        r_in_l      <= IN_L;
        r_in_r      <= IN_R;
        r_gain_used <= r_gain;
        r_gain      <= w_gain_nxt;
      end
      if (r_state == c_ST_MUL_L) r_hold_l <= w_sat;
      if (r_state == c_ST_MUL_R) begin
        r_out_l <= r_hold_l;
        r_out_r <= w_sat;
      end
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  assign OUT_VLD   = w_out_vld;
  assign OUT_L     = r_out_l;
  assign OUT_R     = r_out_r;
  assign CUR_GAIN  = r_gain;
  assign RAMP_BUSY = (r_gain != w_target);
  assign DROP_CNT  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_snd_volramp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_snd_volramp : directed scoreboard bench for snd_volramp (step 1 and 16).
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_snd_volramp;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VLD = 1'b0;
  logic [15:0] IN_L = 16'd0;
  logic [15:0] IN_R = 16'd0;
  logic [7:0]  REG_VOLUME = 8'd128;
  logic        REG_MUTE = 1'b0;
  logic        OUT_VLD;
  logic [15:0] OUT_L;
  logic [15:0] OUT_R;
  logic [7:0]  CUR_GAIN;
  logic        RAMP_BUSY;
  logic [7:0]  DROP_CNT;

  logic        IN_VLD2 = 1'b0;
  logic [7:0]  REG_VOLUME2 = 8'd0;
  logic        REG_MUTE2 = 1'b0;
  logic        OUT_VLD2;
  logic [15:0] OUT_L2;
  logic [15:0] OUT_R2;
  logic [7:0]  CUR_GAIN2;
  logic        RAMP_BUSY2;
  logic [7:0]  DROP_CNT2;

  snd_volramp #(.RAMP_STEP(1)) dut (
    .CLK(CLK), .RST(RST), .IN_VLD(IN_VLD), .IN_L(IN_L), .IN_R(IN_R),
    .REG_VOLUME(REG_VOLUME), .REG_MUTE(REG_MUTE), .OUT_VLD(OUT_VLD),
    .OUT_L(OUT_L), .OUT_R(OUT_R), .CUR_GAIN(CUR_GAIN),
    .RAMP_BUSY(RAMP_BUSY), .DROP_CNT(DROP_CNT)
  );

  snd_volramp #(.RAMP_STEP(16)) dut16 (
    .CLK(CLK), .RST(RST), .IN_VLD(IN_VLD2), .IN_L(IN_L), .IN_R(IN_R),
    .REG_VOLUME(REG_VOLUME2), .REG_MUTE(REG_MUTE2), .OUT_VLD(OUT_VLD2),
    .OUT_L(OUT_L2), .OUT_R(OUT_R2), .CUR_GAIN(CUR_GAIN2),
    .RAMP_BUSY(RAMP_BUSY2), .DROP_CNT(DROP_CNT2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   m_gain = 0;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] model_mul(input logic [15:0] s, input int g);
    longint p;
    p = longint'($signed(s)) * longint'(g);
    p = (p + 64) >>> 7;
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  function automatic int model_step(input int cur, input int tgt, input int step);
    if (tgt >= cur) return (tgt - cur <= step) ? tgt : cur + step;
    return (cur - tgt <= step) ? tgt : cur - step;
  endfunction

  function automatic int tgt_main();
    return REG_MUTE ? 0 : int'(REG_VOLUME);
  endfunction

  // Push the expectation, pulse IN_VLD, wait until the DUT is back in IDLE.
  task automatic send_exp(input logic [15:0] l, input logic [15:0] r,
                          input logic [15:0] el, input logic [15:0] er);
    exp_t e;
    IN_L   = l;
    IN_R   = r;
    IN_VLD = 1'b1;
    e.l = el;
    e.r = er;
    e.due = cyc + 3;
    sb.push_back(e);
    m_gain = model_step(m_gain, tgt_main(), 1);
    @(negedge CLK);
    IN_VLD = 1'b0;
    repeat (3) @(negedge CLK);
    chk("cur_gain", 32'(CUR_GAIN), 32'(m_gain));
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    send_exp(l, r, model_mul(l, m_gain), model_mul(r, m_gain));
  endtask

  task automatic send16();
    IN_VLD2 = 1'b1;
    @(negedge CLK);
    IN_VLD2 = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (OUT_VLD === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_vld", 32'(OUT_VLD), 32'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("latency", 32'(cyc), 32'(mon_e.due));
        chk("out_l", 32'(OUT_L), 32'(mon_e.l));
        chk("out_r", 32'(OUT_R), 32'(mon_e.r));
      end
    end
  end

  initial begin
    exp_t e;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_out_vld", 32'(OUT_VLD), 32'(0));
    chk("rst_out_l", 32'(OUT_L), 32'(0));
    chk("rst_out_r", 32'(OUT_R), 32'(0));
    chk("rst_gain", 32'(CUR_GAIN), 32'(0));
    chk("rst_drop", 32'(DROP_CNT), 32'(0));
    chk("rst_busy", 32'(RAMP_BUSY), 32'(1));
    chk("rst_gain16", 32'(CUR_GAIN2), 32'(0));
    RST = 1'b0;
    @(negedge CLK);

    // RAMP_STEP=16: up to 128 and back down to 0, 8 pairs each way
    REG_VOLUME2 = 8'd128;
    for (int k = 1; k <= 8; k++) begin
      send16();
      chk("gain16_up", 32'(CUR_GAIN2), 32'(16 * k));
    end
    chk("busy16_up", 32'(RAMP_BUSY2), 32'(0));
    REG_MUTE2 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      send16();
      chk("gain16_dn", 32'(CUR_GAIN2), 32'(128 - 16 * k));
    end
    chk("busy16_dn", 32'(RAMP_BUSY2), 32'(0));

    // First pair after reset uses gain 0
    send_exp(16'd1000, 16'(-1000), 16'd0, 16'd0);
    chk("first_gain", 32'(CUR_GAIN), 32'(1));
    chk("first_busy", 32'(RAMP_BUSY), 32'(1));
    repeat (127) send(16'd300, 16'(-300));
    chk("ramp_gain128", 32'(CUR_GAIN), 32'(128));
    chk("ramp_busy128", 32'(RAMP_BUSY), 32'(0));

    send_exp(16'h1234, 16'hFFFB, 16'h1234, 16'hFFFB);

    REG_VOLUME = 8'd255;
    repeat (127) send(16'd12345, 16'(-23456));
    chk("gain255", 32'(CUR_GAIN), 32'(255));
    send_exp(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000);

    REG_VOLUME = 8'd64;
    repeat (191) send(16'd777, 16'(-777));
    chk("gain64", 32'(CUR_GAIN), 32'(64));
    send_exp(16'd3, 16'd1, 16'd2, 16'd1);
    send_exp(16'hFFFF, 16'hFFFD, 16'h0000, 16'hFFFF);

    REG_VOLUME = 8'd128;
    repeat (64) send(16'd5000, 16'(-5000));
    chk("gain_back128", 32'(CUR_GAIN), 32'(128));

    REG_MUTE = 1'b1;
    repeat (68) send(16'd2000, 16'd100);
    chk("mute_gain60", 32'(CUR_GAIN), 32'(60));
    chk("mute_busy", 32'(RAMP_BUSY), 32'(1));
    REG_MUTE = 1'b0;
    REG_VOLUME = 8'd200;
    repeat (140) send(16'd2000, 16'(-2000));
    chk("gain200", 32'(CUR_GAIN), 32'(200));
    chk("busy200", 32'(RAMP_BUSY), 32'(0));

    // Back-to-back: IN_VLD high two cycles -> one output, one drop
    IN_L = 16'd4000;
    IN_R = 16'(-4000);
    IN_VLD = 1'b1;
    e.l = model_mul(IN_L, m_gain);
    e.r = model_mul(IN_R, m_gain);
    e.due = cyc + 3;
    sb.push_back(e);
    m_gain = model_step(m_gain, tgt_main(), 1);
    @(negedge CLK);
    @(negedge CLK);
    IN_VLD = 1'b0;
    repeat (2) @(negedge CLK);
    chk("drop_b2b", 32'(DROP_CNT), 32'(1));

    // Hold IN_VLD for 1200 cycles: accepts every 4th cycle, drop counter saturates
    IN_L = 16'd1111;
    IN_R = 16'd2222;
    IN_VLD = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      if (i % 4 == 0) begin
        e.l = model_mul(IN_L, m_gain);
        e.r = model_mul(IN_R, m_gain);
        e.due = cyc + 3;
        sb.push_back(e);
        m_gain = model_step(m_gain, tgt_main(), 1);
      end
      @(negedge CLK);
    end
    IN_VLD = 1'b0;
    repeat (4) @(negedge CLK);
    chk("drop_sat", 32'(DROP_CNT), 32'(255));

    // Reset during MUL_R aborts the pair
    IN_L = 16'd1000;
    IN_R = 16'd1000;
    IN_VLD = 1'b1;
    @(negedge CLK);
    IN_VLD = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("abort_out_vld", 32'(OUT_VLD), 32'(0));
    chk("abort_out_l", 32'(OUT_L), 32'(0));
    chk("abort_out_r", 32'(OUT_R), 32'(0));
    chk("abort_gain", 32'(CUR_GAIN), 32'(0));
    chk("abort_drop", 32'(DROP_CNT), 32'(0));
    repeat (3) @(negedge CLK);
    chk("abort_hold_vld", 32'(OUT_VLD), 32'(0));
    RST = 1'b0;
    m_gain = 0;
    @(negedge CLK);
    send_exp(16'd1000, 16'(-1000), 16'd0, 16'd0);
    chk("post_rst_gain", 32'(CUR_GAIN), 32'(1));
    repeat (2) @(negedge CLK);
    chk("sb_empty", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
